// File: rtl/girl_anim_ctrl.sv
// Girl sprite animation sequencer and 20x40 ROM address generator.
// Optional build macro GIRL_ANIM_MIRROR_EN: left run reuses right-run ROMs with column mirroring.
module girl_anim_ctrl #(
    parameter int SPR_W = 20,
    parameter int SPR_H = 40,
    parameter int HOLD  = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        move_left,
    input  logic        move_right,
    input  logic [9:0]  PosX,
    input  logic [9:0]  PosY,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [2:0]  frame_sel,
    output logic [10:0] sprite_addr,
    output logic        sprite_on
);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [2:0] {IDLE, R_A, R_B, L_A, L_B} state_t;

    state_t        state, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          go_r, go_l, in_r, in_l;

    function automatic logic [2:0] sel_of(input state_t s);
        case (s)
            R_A:     sel_of = 3'd1;
            R_B:     sel_of = 3'd2;
`ifdef GIRL_ANIM_MIRROR_EN
            L_A:     sel_of = 3'd1;
            L_B:     sel_of = 3'd2;
`else
            L_A:     sel_of = 3'd3;
            L_B:     sel_of = 3'd4;
`endif
            default: sel_of = 3'd0;
        endcase
    endfunction

    assign go_r = move_right & ~move_left;
    assign go_l = move_left & ~move_right;
    assign in_r = (state == R_A) || (state == R_B);
    assign in_l = (state == L_A) || (state == L_B);

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        if (!go_r && !go_l) begin
            nxt     = IDLE;
            cnt_nxt = '0;
        end else if (go_r && !in_r) begin
            nxt     = R_A;
            cnt_nxt = '0;
        end else if (go_l && !in_l) begin
            nxt     = L_A;
            cnt_nxt = '0;
        end else if (cnt == CW'(HOLD - 1)) begin
            cnt_nxt = '0;
            case (state)
                R_A:     nxt = R_B;
                R_B:     nxt = R_A;
                L_A:     nxt = L_B;
                L_B:     nxt = L_A;
                default: nxt = IDLE;
            endcase
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    // Image only changes on the frame tick, so frame_sel is stable for the whole frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_sel <= 3'd0;
        end else if (frame_tick) begin
            state     <= nxt;
            cnt       <= cnt_nxt;
            frame_sel <= sel_of(nxt);
        end
    end

    logic [9:0]  col, row;
    logic [10:0] col_eff, lin;
    logic        hit;

    assign col = DrawX - PosX;
    assign row = DrawY - PosY;
    assign hit = (DrawX >= PosX) && (32'(col) < SPR_W) &&
                 (DrawY >= PosY) && (32'(row) < SPR_H);
`ifdef GIRL_ANIM_MIRROR_EN
    assign col_eff = in_l ? (11'(SPR_W - 1) - 11'(col)) : 11'(col);
`else
    assign col_eff = 11'(col);
`endif
    assign lin = 11'(row) * 11'(SPR_W) + col_eff;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sprite_on   <= 1'b0;
            sprite_addr <= '0;
        end else begin
            sprite_on   <= hit;
            sprite_addr <= hit ? lin : 11'd0;
        end
    end
endmodule

// File: tb/tb_girl_anim_ctrl.sv
// Scoreboard bench for girl_anim_ctrl: stimulus queues expectations, a monitor compares them.
module tb_girl_anim_ctrl;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_tick, move_left, move_right;
    logic [9:0]  PosX, PosY, DrawX, DrawY;
    logic [2:0]  frame_sel;
    logic [10:0] sprite_addr;
    logic        sprite_on;

    girl_anim_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .move_left(move_left), .move_right(move_right),
        .PosX(PosX), .PosY(PosY), .DrawX(DrawX), .DrawY(DrawY),
        .frame_sel(frame_sel), .sprite_addr(sprite_addr), .sprite_on(sprite_on)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        int          due;
        bit          chk_sel;
        logic [2:0]  sel;
        bit          chk_addr;
        logic        on;
        logic [10:0] addr;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    event chk_ev;

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: compares every queued expectation whose due cycle has been reached.
    initial begin
        forever begin
            @(negedge Clk or chk_ev);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due <= cyc) begin
                    if (sb[i].chk_sel) begin
                        n_chk++;
                        if (frame_sel !== sb[i].sel) begin
                            n_fail++;
                            $display("FAIL %s frame_sel got %0d want %0d (cyc %0d)",
                                     sb[i].name, frame_sel, sb[i].sel, cyc);
                        end
                    end
                    if (sb[i].chk_addr) begin
                        n_chk++;
                        if (sprite_on !== sb[i].on || sprite_addr !== sb[i].addr) begin
                            n_fail++;
                            $display("FAIL %s on/addr got %0b/%0d want %0b/%0d (cyc %0d)",
                                     sb[i].name, sprite_on, sprite_addr, sb[i].on, sb[i].addr, cyc);
                        end
                    end
                    sb.delete(i);
                end
            end
        end
    end

    task automatic push_sel(input string nm, input int due, input logic [2:0] s);
        exp_t e;
        e = '{name: nm, due: due, chk_sel: 1'b1, sel: s, chk_addr: 1'b0, on: 1'b0, addr: 11'd0};
        sb.push_back(e);
    endtask

    task automatic push_addr(input string nm, input int due, input logic on, input logic [10:0] a);
        exp_t e;
        e = '{name: nm, due: due, chk_sel: 1'b0, sel: 3'd0, chk_addr: 1'b1, on: on, addr: a};
        sb.push_back(e);
    endtask

    // One frame: tick with the given keys, check latency-1 update and mid-frame stability
    // while the keys are scrambled between ticks.
    task automatic tick(input logic l, input logic r, input logic [2:0] s, input string nm);
        @(negedge Clk);
        move_left = l; move_right = r; frame_tick = 1'b1;
        push_sel(nm, cyc + 1, s);
        @(negedge Clk);
        frame_tick = 1'b0;
        move_left = ~l; move_right = r ^ l;
        push_sel({nm, "_hold"}, cyc + 2, s);
        repeat (3) @(negedge Clk);
    endtask

    task automatic draw(input int px, input int py, input int dx, input int dy,
                        input logic on, input int a, input string nm);
        @(negedge Clk);
        PosX = 10'(px); PosY = 10'(py); DrawX = 10'(dx); DrawY = 10'(dy);
        push_addr(nm, cyc + 1, on, 11'(a));
    endtask

    logic [2:0] run_seq [10] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1};
`ifdef GIRL_ANIM_MIRROR_EN
    localparam logic [2:0] LA = 3'd1, LB = 3'd2;
    localparam int MIR_ADDR = 39;
`else
    localparam logic [2:0] LA = 3'd3, LB = 3'd4;
    localparam int MIR_ADDR = 20;
`endif

    initial begin
        Reset = 1'b1; frame_tick = 1'b0; move_left = 1'b0; move_right = 1'b0;
        PosX = 10'd100; PosY = 10'd200; DrawX = 10'd100; DrawY = 10'd200;
        repeat (2) @(negedge Clk);
        push_sel("reset_sel", cyc + 1, 3'd0);
        push_addr("reset_addr", cyc + 1, 1'b0, 11'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, run_seq[i], $sformatf("run_r%0d", i));

        tick(1'b0, 1'b0, 3'd0, "no_keys");
        tick(1'b0, 1'b1, 3'd1, "dir_r0");
        tick(1'b0, 1'b1, 3'd1, "dir_r1");
        tick(1'b1, 1'b0, LA, "dir_l0");
        tick(1'b1, 1'b0, LA, "dir_l1");
        tick(1'b1, 1'b0, LA, "dir_l2");
        tick(1'b1, 1'b0, LA, "dir_l3");
        tick(1'b1, 1'b0, LB, "dir_l4");
        tick(1'b1, 1'b1, 3'd0, "both_keys");

        draw(100, 200, 100, 200, 1'b1, 0,   "addr_origin");
        draw(100, 200, 119, 239, 1'b1, 799, "addr_corner");
        draw(100, 200, 105, 210, 1'b1, 205, "addr_mid");
        draw(100, 200, 120, 239, 1'b0, 0,   "addr_right_out");
        draw(100, 200, 99,  200, 1'b0, 0,   "addr_left_out");
        draw(100, 200, 100, 240, 1'b0, 0,   "addr_bottom_out");
        draw(630, 50,  639, 50,  1'b1, 9,   "clip_edge");
        draw(630, 50,  0,   50,  1'b0, 0,   "clip_nowrap");

        tick(1'b1, 1'b0, LA, "mir_left");
        draw(300, 100, 300, 101, 1'b1, MIR_ADDR, "mir_addr");
        tick(1'b0, 1'b0, 3'd0, "mir_idle");

        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, run_seq[i], $sformatf("pre_rst%0d", i));
        draw(300, 100, 301, 100, 1'b1, 1, "pre_rst_addr");
        @(negedge Clk);
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        push_sel("async_rst_sel", cyc, 3'd0);
        push_addr("async_rst_addr", cyc, 1'b0, 11'd0);
        -> chk_ev;
        @(negedge Clk);
        frame_tick = 1'b1; move_right = 1'b1; move_left = 1'b0;
        push_sel("tick_in_reset", cyc + 1, 3'd0);
        @(negedge Clk);
        frame_tick = 1'b0;
        Reset = 1'b0;
        tick(1'b0, 1'b0, 3'd0, "post_rst_idle");
        tick(1'b0, 1'b1, 3'd1, "post_rst_r");

        repeat (4) @(negedge Clk);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/girl_anim_ctrl.md
# girl_anim_ctrl

Animation sequencer and address generator for the girl character sprite. Chooses, once per video frame, which of the five girl sprite ROMs (idle, right-run A/B, left-run A/B) is displayed, and advances the walk cycle while a move input is held. Each pixel clock it converts the current `DrawX`/`DrawY` scan position into the 20×40 sprite ROM address and an in-sprite flag for the color mapper.

## Interface
Parameters:
- `SPR_W`, 20: sprite width in pixels.
- `SPR_H`, 40: sprite height in pixels (`SPR_W*SPR_H` ≤ 2048).
- `HOLD`, 4: video frames each walk-cycle image is held (≥1).

Ports:
- `Clk`  in  1  system/pixel clock; all state on rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `frame_tick`  in  1  one-`Clk`-cycle pulse per video frame (start of vblank).
- `move_left`  in  1  level; left key held.
- `move_right`  in  1  level; right key held.
- `PosX`  in  10  sprite top-left X, screen pixels.
- `PosY`  in  10  sprite top-left Y, screen pixels.
- `DrawX`  in  10  current scan X.
- `DrawY`  in  10  current scan Y.
- `frame_sel`  out  3  ROM select: 0 idle, 1 right A, 2 right B, 3 left A, 4 left B.
- `sprite_addr`  out  11  ROM read address, `row*SPR_W + col`.
- `sprite_on`  out  1  current (registered) pixel lies inside the sprite.

## Operation
- States: `IDLE`, `R_A`, `R_B`, `L_A`, `L_B`. `frame_sel` is a registered decode of the state, codes as listed above.
- The state and the hold counter `cnt` (width `$clog2(HOLD)`, minimum 1) update only in cycles with `frame_tick=1`. All inputs are sampled in that cycle.
- Direction decode:
  - `dir = R` when `move_right & ~move_left`.
  - `dir = L` when `move_left & ~move_right`.
  - Otherwise `dir = none`; both keys pressed counts as none.
- On a tick:
  - `dir = none` → `IDLE`, `cnt=0`.
  - `dir` differs from the current run direction, or the current state is `IDLE` → that direction's A state, `cnt=0`.
  - Same direction → if `cnt==HOLD-1`, toggle A↔B and set `cnt=0`; else `cnt+1`.
- With `HOLD=1` the image toggles A/B on every tick.
- Address path, computed fresh every cycle:
  - `col = DrawX-PosX`, `row = DrawY-PosY`, both 10-bit unsigned.
  - `sprite_on = (DrawX>=PosX) & (col<SPR_W) & (DrawY>=PosY) & (row<SPR_H)`.
  - `sprite_addr = row*SPR_W + col` truncated to 11 bits when on, else 0.
  - There is no wrap-around: a sprite clipped at the right/bottom screen edge simply produces no hits past 639/479.

## Timing
- Reset values: state `IDLE`, `cnt=0`, `frame_sel=0`, `sprite_addr=0`, `sprite_on=0`.
- Reset is honored immediately and asynchronously, including mid-frame or mid-cycle.
- `frame_sel` changes on the `Clk` edge following the tick cycle (latency 1) and is constant for the rest of the frame. There is no mid-frame image change.
- `sprite_addr`/`sprite_on` are registered with latency exactly 1 `Clk` from `DrawX`/`DrawY`/`PosX`/`PosY`. The color mapper delays its `DrawX`/`DrawY` compare by one cycle to match.
- Move inputs that change between ticks have no effect until the next tick.
- A tick arriving while `Reset` is asserted is ignored.

## Configuration
- `GIRL_ANIM_MIRROR_EN` defined:
  - Left run reuses the right-run ROMs, so `L_A`/`L_B` output `frame_sel` 1/2.
  - While in `L_A`/`L_B`, the column is mirrored: `sprite_addr = row*SPR_W + (SPR_W-1-col)`.
  - Codes 3/4 are never produced, so the left-run ROMs can be dropped.
- Undefined: behaviour exactly as described in Operation, with no mirroring.

## Test plan
- Reset mid-run (state `R_B`): assert `Reset` asynchronously → `frame_sel=0`, `sprite_on=0`, `sprite_addr=0` without a clock edge. After release, next tick with no keys → `frame_sel` stays 0.
- `HOLD=4`, `move_right` held, 10 ticks → `frame_sel` sequence 1,1,1,1,2,2,2,2,1,1. Each change lands 1 cycle after its tick.
- Direction changes:
  - Right held 2 ticks, then left → third tick gives `frame_sel=3` with `cnt` restarted (next toggle to 4 is 4 ticks later).
  - Both keys held → 0.
- `PosX=100`, `PosY=200`:
  - `DrawX=100`, `DrawY=200` → next cycle `sprite_on=1`, addr 0.
  - (119,239) → addr 799.
  - (120,239) or (99,200) → `sprite_on=0`, addr 0.
- `PosX=630` (clipped): `DrawX=639`, `DrawY=PosY` → addr 9. `DrawX=0` → `sprite_on=0`.
- With `GIRL_ANIM_MIRROR_EN`: left held → `frame_sel=1`, and at (PosX, PosY+1) `sprite_addr=39`.
